// File: rtl/axi_addr_remap.sv
// AXI4 N-window address remapper; unmapped accesses are answered locally with DECERR.
// Define AXI_REMAP_STATS_EN to add the derr_wr_cnt/derr_rd_cnt DECERR counters.
module axi_addr_remap #(
    parameter int ADDR_W   = 36,
    parameter int DATA_W   = 64,
    parameter int ID_W     = 4,
    parameter int NREGIONS = 1,
    parameter logic [NREGIONS*ADDR_W-1:0] MATCH_BASE  = 36'h0_0000_0000,
    parameter logic [NREGIONS*ADDR_W-1:0] MATCH_MASK  = 36'hF_8000_0000,
    parameter logic [NREGIONS*ADDR_W-1:0] TARGET_BASE = 36'h8_0000_0000,
    parameter int OUTS_W   = 4,
    localparam int STRB_W  = DATA_W/8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [ID_W-1:0]   s_axi_awid,
    input  logic [7:0]        s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,
    input  logic              s_axi_awlock,
    input  logic [3:0]        s_axi_awcache,
    input  logic [2:0]        s_axi_awprot,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic [STRB_W-1:0] s_axi_wstrb,
    input  logic              s_axi_wlast,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    output logic [ID_W-1:0]   s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arlock,
    input  logic [3:0]        s_axi_arcache,
    input  logic [2:0]        s_axi_arprot,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [ID_W-1:0]   s_axi_rid,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [ID_W-1:0]   m_axi_awid,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic              m_axi_awlock,
    output logic [3:0]        m_axi_awcache,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [STRB_W-1:0] m_axi_wstrb,
    output logic              m_axi_wlast,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    input  logic [ID_W-1:0]   m_axi_bid,
    input  logic [1:0]        m_axi_bresp,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [ID_W-1:0]   m_axi_arid,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arlock,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [ID_W-1:0]   m_axi_rid,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast
`ifdef AXI_REMAP_STATS_EN
    ,
    output logic [31:0]       derr_wr_cnt,
    output logic [31:0]       derr_rd_cnt
`endif
);

    typedef enum logic [1:0] {W_IDLE, W_FWD, W_SINK, W_ERRB} w_state_t;
    typedef enum logic {R_IDLE, R_ERR} r_state_t;

    localparam logic [OUTS_W-1:0] OUTS_MAX = '1;

    w_state_t          w_state, w_next;
    r_state_t          r_state, r_next;
    logic [OUTS_W-1:0] wr_outs, rd_outs;
    logic [ID_W-1:0]   wr_err_id, rd_err_id;
    logic [7:0]        rd_err_len, rd_beat;
    logic              aw_hit, ar_hit;
    logic [ADDR_W-1:0] aw_xaddr, ar_xaddr;
    logic              wr_inc, wr_dec, rd_inc, rd_dec;
    logic              aw_miss_acc, ar_miss_acc, rd_err_adv;

    // Returns {hit, translated addr}; scanning downward lets the lowest index win.
    function automatic logic [ADDR_W:0] decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0] res;
        res = {1'b0, addr};
        for (int i = NREGIONS-1; i >= 0; i--) begin
            if ((addr & MATCH_MASK[i*ADDR_W +: ADDR_W]) == MATCH_BASE[i*ADDR_W +: ADDR_W])
                res = {1'b1, TARGET_BASE[i*ADDR_W +: ADDR_W] | (addr & ~MATCH_MASK[i*ADDR_W +: ADDR_W])};
        end
        return res;
    endfunction

    assign {aw_hit, aw_xaddr} = decode(s_axi_awaddr);
    assign {ar_hit, ar_xaddr} = decode(s_axi_araddr);

    assign m_axi_awaddr  = aw_xaddr;
    assign m_axi_awid    = s_axi_awid;
    assign m_axi_awlen   = s_axi_awlen;
    assign m_axi_awsize  = s_axi_awsize;
    assign m_axi_awburst = s_axi_awburst;
    assign m_axi_awlock  = s_axi_awlock;
    assign m_axi_awcache = s_axi_awcache;
    assign m_axi_awprot  = s_axi_awprot;
    assign m_axi_wdata   = s_axi_wdata;
    assign m_axi_wstrb   = s_axi_wstrb;
    assign m_axi_wlast   = s_axi_wlast;
    assign m_axi_araddr  = ar_xaddr;
    assign m_axi_arid    = s_axi_arid;
    assign m_axi_arlen   = s_axi_arlen;
    assign m_axi_arsize  = s_axi_arsize;
    assign m_axi_arburst = s_axi_arburst;
    assign m_axi_arlock  = s_axi_arlock;
    assign m_axi_arcache = s_axi_arcache;
    assign m_axi_arprot  = s_axi_arprot;

    // Handshake outputs are held low while reset is asserted.
    always_comb begin
        w_next        = w_state;
        s_axi_awready = 1'b0;
        m_axi_awvalid = 1'b0;
        s_axi_wready  = 1'b0;
        m_axi_wvalid  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bid     = m_axi_bid;
        s_axi_bresp   = m_axi_bresp;
        m_axi_bready  = 1'b0;
        wr_inc        = 1'b0;
        aw_miss_acc   = 1'b0;
        if (!reset) begin
            s_axi_bvalid = m_axi_bvalid;
            m_axi_bready = s_axi_bready;
            unique case (w_state)
                W_IDLE: begin
                    if (aw_hit) begin
                        if (wr_outs != OUTS_MAX) begin
                            m_axi_awvalid = s_axi_awvalid;
                            s_axi_awready = m_axi_awready;
                            if (s_axi_awvalid && m_axi_awready) begin
                                wr_inc = 1'b1;
                                w_next = W_FWD;
                            end
                        end
                    end else if (wr_outs == '0) begin
                        s_axi_awready = 1'b1;
                        if (s_axi_awvalid) begin
                            aw_miss_acc = 1'b1;
                            w_next      = W_SINK;
                        end
                    end
                end
                W_FWD: begin
                    m_axi_wvalid = s_axi_wvalid;
                    s_axi_wready = m_axi_wready;
                    if (s_axi_wvalid && m_axi_wready && s_axi_wlast) w_next = W_IDLE;
                end
                W_SINK: begin
                    s_axi_wready = 1'b1;
                    if (s_axi_wvalid && s_axi_wlast) w_next = W_ERRB;
                end
                W_ERRB: begin
                    s_axi_bvalid = 1'b1;
                    s_axi_bid    = wr_err_id;
                    s_axi_bresp  = 2'b11;
                    m_axi_bready = 1'b0;
                    if (s_axi_bready) w_next = W_IDLE;
                end
                default: w_next = W_IDLE;
            endcase
        end
    end

    assign wr_dec = m_axi_bvalid && m_axi_bready;

    always_comb begin
        r_next        = r_state;
        s_axi_arready = 1'b0;
        m_axi_arvalid = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rdata   = m_axi_rdata;
        s_axi_rid     = m_axi_rid;
        s_axi_rresp   = m_axi_rresp;
        s_axi_rlast   = m_axi_rlast;
        m_axi_rready  = 1'b0;
        rd_inc        = 1'b0;
        ar_miss_acc   = 1'b0;
        rd_err_adv    = 1'b0;
        if (!reset) begin
            unique case (r_state)
                R_IDLE: begin
                    s_axi_rvalid = m_axi_rvalid;
                    m_axi_rready = s_axi_rready;
                    if (ar_hit) begin
                        if (rd_outs != OUTS_MAX) begin
                            m_axi_arvalid = s_axi_arvalid;
                            s_axi_arready = m_axi_arready;
                            rd_inc        = s_axi_arvalid && m_axi_arready;
                        end
                    end else if (rd_outs == '0) begin
                        s_axi_arready = 1'b1;
                        if (s_axi_arvalid) begin
                            ar_miss_acc = 1'b1;
                            r_next      = R_ERR;
                        end
                    end
                end
                R_ERR: begin
                    s_axi_rvalid = 1'b1;
                    s_axi_rdata  = '0;
                    s_axi_rid    = rd_err_id;
                    s_axi_rresp  = 2'b11;
                    s_axi_rlast  = (rd_beat == rd_err_len);
                    if (s_axi_rready) begin
                        if (rd_beat == rd_err_len) r_next = R_IDLE;
                        else rd_err_adv = 1'b1;
                    end
                end
                default: r_next = R_IDLE;
            endcase
        end
    end

    assign rd_dec = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    // Simultaneous increment and decrement leaves the outstanding count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state    <= W_IDLE;
            r_state    <= R_IDLE;
            wr_outs    <= '0;
            rd_outs    <= '0;
            wr_err_id  <= '0;
            rd_err_id  <= '0;
            rd_err_len <= '0;
            rd_beat    <= '0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            if (wr_inc && !wr_dec) wr_outs <= wr_outs + 1'b1;
            else if (!wr_inc && wr_dec) wr_outs <= wr_outs - 1'b1;
            if (rd_inc && !rd_dec) rd_outs <= rd_outs + 1'b1;
            else if (!rd_inc && rd_dec) rd_outs <= rd_outs - 1'b1;
            if (aw_miss_acc) wr_err_id <= s_axi_awid;
            if (ar_miss_acc) begin
                rd_err_id  <= s_axi_arid;
                rd_err_len <= s_axi_arlen;
                rd_beat    <= '0;
            end else if (rd_err_adv) begin
                rd_beat <= rd_beat + 8'd1;
            end
        end
    end

`ifdef AXI_REMAP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            derr_wr_cnt <= '0;
            derr_rd_cnt <= '0;
        end else begin
            if (aw_miss_acc && derr_wr_cnt != 32'hFFFF_FFFF) derr_wr_cnt <= derr_wr_cnt + 32'd1;
            if (ar_miss_acc && derr_rd_cnt != 32'hFFFF_FFFF) derr_rd_cnt <= derr_rd_cnt + 32'd1;
        end
    end
`endif

endmodule
